seq_pattern_fsm: RTL and testbench

- Parametrised serial pattern detector; the successor to the team's fixed-topology single-bit Moore detectors.
- Pattern length, pattern value and don't-care mask are programmable at run time instead of being baked into state encodings.
- Overlapping or non-overlapping match modes are selectable.
- Sits on a serial bit stream qualified by a valid strobe and produces a registered Moore-style match flag for downstream control logic.

---
 rtl/seq_pattern_pkg.sv | 21 ++
 rtl/seq_pattern_fsm_if.sv | 29 ++
 rtl/seq_pattern_cmp.sv | 33 +++
 rtl/seq_pattern_fsm.sv | 108 ++++++++++
 tb/tb_seq_pattern_fsm.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/seq_pattern_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } state_e;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Active pattern length is kept inside 2..max_len
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len < 2) return 2;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_pattern_fsm_if.sv
// Serial bit stream, configuration and match result bundle for seq_pattern_fsm.
interface seq_pattern_fsm_if
  import seq_pattern_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic               w;
  logic               w_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [MAX_LEN-1:0] cfg_mask;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output w, w_valid, cfg_load, cfg_pat, cfg_mask, cfg_len, cfg_overlap,
    input  z, match_cnt
  );

  modport slave (
    input  w, w_valid, cfg_load, cfg_pat, cfg_mask, cfg_len, cfg_overlap,
    output z, match_cnt
  );
endinterface

// File: rtl/seq_pattern_cmp.sv
// Masked window comparator: checks the newest len bits (stored history plus
// incoming bit) against the programmed pattern; pattern bit len-1 is the newest.
module seq_pattern_cmp
  import seq_pattern_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W  = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-2:0] i_hist,
  input  logic               i_w,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [MAX_LEN-1:0] i_mask,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match_c
);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  // w_ext[k] is the bit received k bits ago (k=0 is the incoming bit)
  logic [MAX_LEN-1:0] w_ext;
  logic [IDX_W-1:0]   w_age;

  assign w_ext = {i_hist, i_w};

  always_comb begin
    o_match_c = 1'b1;
    w_age     = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      w_age = IDX_W'(i_len - LEN_W'(1) - LEN_W'(j));
      if ((LEN_W'(j) < i_len) && !((w_ext[w_age] ~^ i_pat[j]) | ~i_mask[j]))
        o_match_c = 1'b0;
    end
  end
endmodule

// File: rtl/seq_pattern_fsm.sv
// Programmable serial pattern detector with registered one-cycle match flag.
// Optional saturating match counter enabled by SEQ_PATTERN_MATCH_COUNT_EN.
module seq_pattern_fsm
  import seq_pattern_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_pattern_fsm_if.slave bus
);
  localparam int unsigned LEN_W = len_w(MAX_LEN);

  // Only len-1 past bits are ever needed next to the incoming one
  state_e             r_state;
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [MAX_LEN-1:0] r_mask;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_z;

  state_e             w_state_next;
  logic [MAX_LEN-2:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_fill_acc;
  logic               w_cmp_c;
  logic               w_hit_c;
  logic               w_z_next;

  seq_pattern_cmp #(.MAX_LEN(MAX_LEN)) u_cmp (
    .i_hist   (r_hist),
    .i_w      (bus.w),
    .i_pat    (r_pat),
    .i_mask   (r_mask),
    .i_len    (r_len),
    .o_match_c(w_cmp_c)
  );

  assign w_fill_acc = (r_state == ARMED) ? r_len : r_fill + LEN_W'(1);
  assign w_hit_c    = w_cmp_c && (w_fill_acc == r_len);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= '0;
      r_mask    <= '1;
      r_len     <= LEN_W'(2);
      r_overlap <= 1'b1;
      r_z       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hist  <= w_hist_next;
      r_fill  <= w_fill_next;
      r_z     <= w_z_next;
      if (bus.cfg_load) begin
        r_pat     <= bus.cfg_pat;
        r_mask    <= bus.cfg_mask;
        r_len     <= LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
        r_overlap <= bus.cfg_overlap;
      end
    end
  end

  // Next-state: history shift, fill tracking, non-overlap restart
  always_comb begin
    w_hist_next  = r_hist;
    w_fill_next  = r_fill;
    w_state_next = r_state;
    if (bus.cfg_load) begin
      w_hist_next = '0;
      w_fill_next = '0;
    end else if (bus.w_valid) begin
      w_hist_next = (MAX_LEN-1)'({r_hist, bus.w});
      w_fill_next = (w_hit_c && !r_overlap) ? '0 : w_fill_acc;
    end
    if (w_fill_next == '0)        w_state_next = IDLE;
    else if (w_fill_next == r_len) w_state_next = ARMED;
    else                           w_state_next = FILLING;
  end

  // Output: match flag only on an accepted, non-discarded bit
  always_comb begin
    w_z_next = 1'b0;
    if (!bus.cfg_load && bus.w_valid && w_hit_c) w_z_next = 1'b1;
  end

  assign bus.z = r_z;

`ifdef SEQ_PATTERN_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.cfg_load) r_cnt <= '0;
    else if (w_z_next && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.match_cnt = r_cnt;
`else
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Directed self-checking bench for seq_pattern_fsm (MAX_LEN=8, CNT_W=8).
module tb_seq_pattern_fsm;

`ifdef SEQ_PATTERN_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seq_pattern_fsm_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

  seq_pattern_fsm #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [7:0] mask,
                      input logic [3:0] len, input logic ov);
    bus.cfg_pat     = pat;
    bus.cfg_mask    = mask;
    bus.cfg_len     = len;
    bus.cfg_overlap = ov;
    bus.cfg_load    = 1'b1;
    tick();
    bus.cfg_load    = 1'b0;
    chk("load_z", 32'(bus.z), 32'd0);
    chk("load_cnt", 32'(bus.match_cnt), 32'd0);
  endtask

  task automatic bit_step(input logic v, input logic b, input logic exp_z, input string tag);
    bus.w       = b;
    bus.w_valid = v;
    tick();
    bus.w_valid = 1'b0;
    chk(tag, 32'(bus.z), 32'(exp_z));
  endtask

  // bits[i] / expz[i] belong to the i-th accepted bit in arrival order
  task automatic stream(input int n, input logic [15:0] bits, input logic [15:0] expz,
                        input string tag);
    for (int i = 0; i < n; i++) bit_step(1'b1, bits[i], expz[i], tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.w           = 1'b0;
    bus.w_valid     = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pat     = '0;
    bus.cfg_mask    = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    tick();
    tick();
    chk("reset_z", 32'(bus.z), 32'd0);
    chk("reset_cnt", 32'(bus.match_cnt), 32'd0);
    reset = 1'b0;

    // Overlapping 1101: arrivals 1,0,1,1,0,1,1 -> hits on 4th and 7th
    load(8'h0D, 8'hFF, 4'd4, 1'b1);
    stream(7, 16'b110_1101, 16'b100_1000, "ovl_z");
    chk("ovl_cnt", 32'(bus.match_cnt), CNT_EN ? 32'd2 : 32'd0);

    // Non-overlapping: 7th bit finds fill=3
    load(8'h0D, 8'hFF, 4'd4, 1'b0);
    stream(7, 16'b110_1101, 16'b000_1000, "novl_z");
    chk("novl_cnt", 32'(bus.match_cnt), CNT_EN ? 32'd1 : 32'd0);

    // len=3 zeros with w_valid toggling
    load(8'h00, 8'hFF, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_step(1'b1, 1'b0, (i >= 2), "zeros_valid_z");
      bit_step(1'b0, 1'b0, 1'b0, "zeros_idle_z");
    end
    chk("zeros_cnt", 32'(bus.match_cnt), CNT_EN ? 32'd3 : 32'd0);

    // Middle-bits mask: outer bits are don't care
    load(8'h06, 8'h06, 4'd4, 1'b1);
    stream(4, 16'b1111, 16'b1000, "mask_1111_z");
    load(8'h06, 8'h06, 4'd4, 1'b1);
    stream(4, 16'b0110, 16'b1000, "mask_0110_z");

    // All-zero mask matches every bit once filled
    load(8'hA5, 8'h00, 4'd3, 1'b1);
    stream(4, 16'b0101, 16'b1100, "mask0_z");

    // cfg_load after 3 matching bits discards the concurrent bit and restarts
    load(8'h0D, 8'hFF, 4'd4, 1'b1);
    stream(3, 16'b101, 16'b000, "pre_load_z");
    bus.w           = 1'b1;
    bus.w_valid     = 1'b1;
    bus.cfg_load    = 1'b1;
    tick();
    bus.cfg_load    = 1'b0;
    bus.w_valid     = 1'b0;
    chk("mid_load_z", 32'(bus.z), 32'd0);
    bit_step(1'b1, 1'b1, 1'b0, "post_load_4th_z");
    stream(4, 16'b1101, 16'b1000, "post_load_full_z");

    // Reset on the final matching bit wins
    load(8'h0D, 8'hFF, 4'd4, 1'b1);
    stream(3, 16'b101, 16'b000, "pre_reset_z");
    bus.w       = 1'b1;
    bus.w_valid = 1'b1;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    bus.w_valid = 1'b0;
    chk("reset_hit_z", 32'(bus.z), 32'd0);
    chk("reset_hit_cnt", 32'(bus.match_cnt), 32'd0);

    // Reset configuration: pattern 0, len 2, overlap
    stream(3, 16'b000, 16'b110, "reset_cfg_z");

    // cfg_len=0 clamps to 2
    load(8'h03, 8'hFF, 4'd0, 1'b1);
    stream(3, 16'b111, 16'b110, "clamp_lo_z");

    // cfg_len=15 clamps to 8
    load(8'hFF, 8'hFF, 4'd15, 1'b1);
    stream(9, 16'b1_1111_1111, 16'b1_1000_0000, "clamp_hi_z");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
